// File: rtl/wrf_pkg.sv
// rtl/wrf_pkg.sv - shared constants and clear-engine state type for the WRF slice
package wrf_pkg;

  localparam int WRF_SLICE_WIDTH = 4;
  localparam int WRF_DEPTH       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/wrf_write_stage.sv
// rtl/wrf_write_stage.sv - one-entry write staging register with accept/commit and read-bypass match
module wrf_write_stage
  import wrf_pkg::*;
#(
  parameter int WIDTH = WRF_SLICE_WIDTH,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  input  logic             i_wr_ready,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_hold,
  input  logic [AW-1:0]    i_rd_addr_a,
  input  logic [AW-1:0]    i_rd_addr_b,
  output logic             o_stage_valid,
  output logic [AW-1:0]    o_stage_addr,
  output logic [WIDTH-1:0] o_stage_data,
  output logic             o_commit,
  output logic             o_hit_a,
  output logic             o_hit_b
);

  logic             r_valid;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  assign w_accept = i_wr_valid && i_wr_ready;
  assign o_commit = r_valid && !i_hold;

  // A new accept overrides the clear-on-commit, giving one write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_addr  <= i_wr_addr;
      r_data  <= i_wr_data;
    end else if (o_commit) begin
      r_valid <= 1'b0;
    end
  end

  assign o_stage_valid = r_valid;
  assign o_stage_addr  = r_addr;
  assign o_stage_data  = r_data;
  assign o_hit_a       = r_valid && (r_addr == i_rd_addr_a);
  assign o_hit_b       = r_valid && (r_addr == i_rd_addr_b);

endmodule

// File: rtl/wrf_slice_regs.sv
// rtl/wrf_slice_regs.sv - 4-bit WRF slice: staged write, 16-entry array, clear engine, two bypassed read ports
module wrf_slice_regs
  import wrf_pkg::*;
#(
  parameter int WIDTH = WRF_SLICE_WIDTH,
  parameter int DEPTH = WRF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             sysclk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_hold,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_clr_busy;

  logic             w_stage_valid;
  logic [AW-1:0]    w_stage_addr;
  logic [WIDTH-1:0] w_stage_data;
  logic             w_commit;
  logic             w_hit_a;
  logic             w_hit_b;
  logic             w_wr_ready;

  assign w_wr_ready = (r_state == IDLE) && !clr_req && (!w_stage_valid || !wr_hold);

  wrf_write_stage #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_stage (
    .clk          (sysclk),
    .rst          (sys_rst),
    .i_wr_valid   (wr_valid),
    .i_wr_ready   (w_wr_ready),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_hold       (wr_hold),
    .i_rd_addr_a  (rd_addr_a),
    .i_rd_addr_b  (rd_addr_b),
    .o_stage_valid(w_stage_valid),
    .o_stage_addr (w_stage_addr),
    .o_stage_data (w_stage_data),
    .o_commit     (w_commit),
    .o_hit_a      (w_hit_a),
    .o_hit_b      (w_hit_b)
  );

  // Stage is always empty in CLEAR, so commit and clear never collide.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == CLEAR) begin
      if (!wr_hold) r_mem[r_clr_cnt] <= '0;
    end else if (w_commit) begin
      r_mem[w_stage_addr] <= w_stage_data;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_clr_cnt  <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b1;
            r_state    <= w_stage_valid ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          if (!w_stage_valid || w_commit) begin
            r_clr_cnt <= '0;
            r_state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (!wr_hold) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
            if (r_clr_cnt == AW'(DEPTH - 1)) begin
              r_state    <= IDLE;
              r_clr_busy <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready  = w_wr_ready;
  assign clr_busy  = r_clr_busy;
  assign rd_data_a = w_hit_a ? w_stage_data : r_mem[rd_addr_a];
  assign rd_data_b = w_hit_b ? w_stage_data : r_mem[rd_addr_b];

endmodule

// File: tb/tb_wrf_slice_regs.sv
// tb/tb_wrf_slice_regs.sv - directed self-checking bench for wrf_slice_regs
module tb_wrf_slice_regs;

  logic       sysclk = 1'b0;
  logic       sys_rst;
  logic [3:0] wr_data;
  logic [3:0] wr_addr;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_hold;
  logic       clr_req;
  logic       clr_busy;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_data_a;
  logic [3:0] rd_addr_b;
  logic [3:0] rd_data_b;

  int checks   = 0;
  int failures = 0;

  wrf_slice_regs dut (
    .sysclk   (sysclk),
    .sys_rst  (sys_rst),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_hold  (wr_hold),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b)
  );

  always #50 sysclk = ~sysclk;

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; wr_valid = 1'b0; wr_hold = 1'b0; clr_req = 1'b0;
    wr_addr = 4'h0; wr_data = 4'h0; rd_addr_a = 4'h0; rd_addr_b = 4'h0;
    repeat (2) @(posedge sysclk);
    #1 sys_rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); #1;
      checks++;
      if (rd_data_a !== 4'h0) begin
        failures++; $display("FAIL reset_rd_a addr=%0d got=%h exp=0", i, rd_data_a);
      end
      checks++;
      if (rd_data_b !== 4'h0) begin
        failures++; $display("FAIL reset_rd_b addr=%0d got=%h exp=0", 15 - i, rd_data_b);
      end
    end
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++;
    if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
  endtask

  task automatic test_write_bypass;
    tick;
    wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 4'hA; rd_addr_a = 4'h3; rd_addr_b = 4'h3; #1;
    checks++;
    if (rd_data_a !== 4'h0) begin failures++; $display("FAIL wr_pre got=%h exp=0", rd_data_a); end
    tick;
    wr_valid = 1'b0; #1;
    checks++;
    if (rd_data_a !== 4'hA) begin failures++; $display("FAIL wr_bypass got=%h exp=a", rd_data_a); end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (rd_data_a !== 4'hA || rd_data_b !== 4'hA) begin
        failures++; $display("FAIL wr_array k=%0d got_a=%h got_b=%h exp=a", k, rd_data_a, rd_data_b);
      end
    end
    wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 4'h1; rd_addr_a = 4'h5;
    tick;
    wr_data = 4'h2; #1;
    checks++;
    if (rd_data_a !== 4'h1) begin failures++; $display("FAIL b2b_first got=%h exp=1", rd_data_a); end
    tick;
    wr_valid = 1'b0; #1;
    checks++;
    if (rd_data_a !== 4'h2) begin failures++; $display("FAIL b2b_bypass got=%h exp=2", rd_data_a); end
    tick;
    checks++;
    if (rd_data_a !== 4'h2) begin failures++; $display("FAIL b2b_final got=%h exp=2", rd_data_a); end
  endtask

  task automatic test_hold;
    wr_valid = 1'b1; wr_addr = 4'h9; wr_data = 4'h7; rd_addr_a = 4'h9; rd_addr_b = 4'h9;
    tick;
    wr_valid = 1'b0; wr_hold = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rd_data_a !== 4'h7 || rd_data_b !== 4'h7) begin
        failures++; $display("FAIL hold_bypass k=%0d got_a=%h got_b=%h exp=7", k, rd_data_a, rd_data_b);
      end
      checks++;
      if (wr_ready !== 1'b0) begin failures++; $display("FAIL hold_ready k=%0d got=%b exp=0", k, wr_ready); end
      tick;
    end
    wr_hold = 1'b0; #1;
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", wr_ready); end
    tick;
    checks++;
    if (rd_data_a !== 4'h7 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL hold_commit got=%h ready=%b exp=7 ready=1", rd_data_a, wr_ready);
    end
  endtask

  task automatic test_clear;
    int n;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 4'hF;
      tick;
    end
    wr_valid = 1'b0;
    tick;
    rd_addr_a = 4'h0; rd_addr_b = 4'hF; #1;
    checks++;
    if (rd_data_a !== 4'hF || rd_data_b !== 4'hF) begin
      failures++; $display("FAIL fill got_a=%h got_b=%h exp=f", rd_data_a, rd_data_b);
    end
    clr_req = 1'b1; #1;
    checks++;
    if (wr_ready !== 1'b0 || clr_busy !== 1'b0) begin
      failures++; $display("FAIL clr_req_idle ready=%b busy=%b exp ready=0 busy=0", wr_ready, clr_busy);
    end
    tick;
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      if (n == 6) begin
        for (int i = 0; i < 16; i++) begin
          rd_addr_a = 4'(i); #1;
          checks++;
          if (rd_data_a !== ((i < 6) ? 4'h0 : 4'hF)) begin
            failures++; $display("FAIL mid_clear addr=%0d got=%h exp=%h", i, rd_data_a, (i < 6) ? 4'h0 : 4'hF);
          end
        end
      end
      n++;
      tick;
    end
    checks++;
    if (n != 16) begin failures++; $display("FAIL clear_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      rd_addr_b = 4'(i); #1;
      checks++;
      if (rd_data_b !== 4'h0) begin failures++; $display("FAIL clear_end addr=%0d got=%h exp=0", i, rd_data_b); end
    end
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL clear_end_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_drain;
    int c;
    wr_valid = 1'b1; wr_addr = 4'h2; wr_data = 4'h5;
    tick;
    clr_req = 1'b1; wr_addr = 4'h4; wr_data = 4'h6; wr_hold = 1'b1; #1;
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL drain_reject_ready got=%b exp=0", wr_ready); end
    tick;
    clr_req = 1'b0; wr_valid = 1'b0;
    c = 0;
    while (clr_busy === 1'b1 && c < 60) begin
      wr_hold = (c < 2) || (c >= 8 && c <= 10);
      rd_addr_a = 4'h2; rd_addr_b = 4'h4; #1;
      if (c == 0) begin
        checks++;
        if (rd_data_a !== 4'h5 || rd_data_b !== 4'h0) begin
          failures++; $display("FAIL drain_bypass got_a=%h got_b=%h exp_a=5 exp_b=0", rd_data_a, rd_data_b);
        end
      end
      if (c == 3) begin
        checks++;
        if (rd_data_a !== 4'h5) begin failures++; $display("FAIL drain_commit got=%h exp=5", rd_data_a); end
      end
      checks++;
      if (wr_ready !== 1'b0) begin failures++; $display("FAIL drain_busy_ready c=%0d got=%b exp=0", c, wr_ready); end
      c++;
      tick;
    end
    wr_hold = 1'b0;
    checks++;
    if (c != 22) begin failures++; $display("FAIL drain_clear_len got=%0d exp=22", c); end
    rd_addr_a = 4'h2; rd_addr_b = 4'h4; #1;
    checks++;
    if (rd_data_a !== 4'h0 || rd_data_b !== 4'h0) begin
      failures++; $display("FAIL drain_end got_a=%h got_b=%h exp=0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_reset_mid_clear;
    for (int i = 10; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 4'hC;
      tick;
    end
    wr_valid = 1'b0;
    tick;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (3) tick;
    rd_addr_a = 4'hC; rd_addr_b = 4'hF; #1;
    checks++;
    if (rd_data_a !== 4'hC || clr_busy !== 1'b1) begin
      failures++; $display("FAIL pre_rst got=%h busy=%b exp=c busy=1", rd_data_a, clr_busy);
    end
    #20 sys_rst = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || rd_data_a !== 4'h0 || rd_data_b !== 4'h0) begin
      failures++; $display("FAIL async_rst busy=%b ready=%b a=%h b=%h exp 0 1 0 0", clr_busy, wr_ready, rd_data_a, rd_data_b);
    end
    tick;
    sys_rst = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); #1;
      checks++;
      if (rd_data_a !== 4'h0) begin failures++; $display("FAIL post_rst addr=%0d got=%h exp=0", i, rd_data_a); end
    end
    tick;
    wr_valid = 1'b1; wr_addr = 4'h1; wr_data = 4'h9; rd_addr_a = 4'h1;
    tick;
    wr_valid = 1'b0; wr_hold = 1'b1;
    #20 sys_rst = 1'b1;
    #1;
    checks++;
    if (rd_data_a !== 4'h0) begin failures++; $display("FAIL rst_mid_write got=%h exp=0", rd_data_a); end
    tick;
    sys_rst = 1'b0; wr_hold = 1'b0;
    tick;
    checks++;
    if (rd_data_a !== 4'h0 || clr_busy !== 1'b0) begin
      failures++; $display("FAIL rst_no_commit got=%h busy=%b exp=0 busy=0", rd_data_a, clr_busy);
    end
  endtask

  initial begin
    test_reset;
    test_write_bypass;
    test_hold;
    test_clear;
    test_drain;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
